div_unit: RTL and testbench

- Multicycle signed 32-bit divider for the MIPS `div` instruction.
- Sits beside the ALU datapath and is operated by the control unit through a start/done handshake.
- Produces quotient (LO) and remainder (HI) with restoring division, one bit per cycle.
- Drives the control unit's divide-by-zero exception input (`divZero`).

---
 rtl/mips_pkg.sv | 17 +
 rtl/div_unit.sv | 118 +++++++++++
 tb/tb_div_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions.
// Holds the divider state encoding, the default operand width and the
// width of the divider's iteration counter.
package mips_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    FIX  = 3'd2,
    DONE = 3'd3,
    ZERO = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Multicycle signed restoring divider for the MIPS div instruction.
// Produces one quotient bit per cycle. The quotient goes to LO and the
// remainder to HI. A zero divisor raises a one-cycle divZero exception.
// Ports:
//   clk, reset    - clock; synchronous active-high reset
//   div_start     - start request, accepted only while idle
//   A, B          - dividend / divisor, two's complement
//   hi_out        - remainder (sign of dividend)
//   lo_out        - quotient (truncated toward zero)
//   div_done      - one-cycle completion pulse
//   divZero       - one-cycle divide-by-zero pulse, coincident with div_done
module div_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_done,
  output logic             divZero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  div_state_e       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             qneg, rneg;

  logic [WIDTH:0]   rem_sh, rem_step;
  logic [WIDTH-1:0] quo_step;
  logic             fits;
  logic [WIDTH-1:0] lo_fix, hi_fix;

  // Magnitude as unsigned WIDTH bits; the most negative value maps to itself.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
  endfunction

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (div_start) state_next = (B == '0) ? ZERO : RUN;
      RUN:     if (cnt == CNT_W'(WIDTH - 1)) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      ZERO:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One restoring step: shift {rem,quo} left, subtract divisor if it fits.
  // rem < divisor always holds between steps, so rem_sh never overflows.
  always_comb begin
    rem_sh   = {rem[WIDTH-1:0], quo[WIDTH-1]};
    fits     = (rem_sh >= {1'b0, dvs});
    rem_step = fits ? (rem_sh - {1'b0, dvs}) : rem_sh;
    quo_step = {quo[WIDTH-2:0], fits};
  end

  // Sign correction of the magnitude results
  always_comb begin
    lo_fix = qneg ? (~quo + WIDTH'(1)) : quo;
    hi_fix = rneg ? (~rem[WIDTH-1:0] + WIDTH'(1)) : rem[WIDTH-1:0];
  end

  // State register, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      qneg     <= 1'b0;
      rneg     <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
      div_done <= 1'b0;
      divZero  <= 1'b0;
    end else begin
      state    <= state_next;
      div_done <= (state_next == DONE) || (state_next == ZERO);
      divZero  <= (state_next == ZERO);
      case (state)
        IDLE: begin
          if (div_start && (B != '0)) begin
            rem  <= '0;
            quo  <= abs_val(A);
            dvs  <= abs_val(B);
            qneg <= A[WIDTH-1] ^ B[WIDTH-1];
            rneg <= A[WIDTH-1];
            cnt  <= '0;
          end
        end
        RUN: begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          lo_out <= lo_fix;
          hi_out <= hi_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: a scoreboard of expected results and
// completion cycles, filled by the driver and drained by a negedge monitor.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        div_start;
  logic [31:0] A, B;
  logic [31:0] hi_out, lo_out;
  logic        div_done, divZero;

  div_unit dut (
    .clk      (clk),
    .reset    (reset),
    .div_start(div_start),
    .A        (A),
    .B        (B),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .div_done (div_done),
    .divZero  (divZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        zero;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference: signed division with truncation toward zero, done in 64 bits
  // so 0x80000000 / -1 wraps to 0x80000000 with remainder 0.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb_l, q, r;
    sa   = longint'($signed(a));
    sb_l = longint'($signed(b));
    q    = sa / sb_l;
    r    = sa % sb_l;
    lo   = q[31:0];
    hi   = r[31:0];
  endtask

  // Drive a one-cycle start; when accepted, push the expected result.
  task automatic do_start(input logic [31:0] a, input logic [31:0] b, input bit accepted);
    exp_t e;
    @(negedge clk);
    A = a;
    B = b;
    div_start = 1'b1;
    if (accepted) begin
      if (b == 32'd0) begin
        e.due  = cyc + 1;
        e.zero = 1'b1;
        e.hi   = last_hi;
        e.lo   = last_lo;
      end else begin
        e.due  = cyc + 34;
        e.zero = 1'b0;
        model(a, b, e.hi, e.lo);
        last_hi = e.hi;
        last_lo = e.lo;
      end
      sb.push_back(e);
    end
    @(negedge clk);
    div_start = 1'b0;
    A = $urandom;
    B = $urandom;
  endtask

  // Wait until the scoreboard drains; returns just after the done cycle's negedge.
  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) chk("idle_wait", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (div_done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 64'(div_done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.due));
        chk("lo_out", 64'(lo_out), 64'(e.lo));
        chk("hi_out", 64'(hi_out), 64'(e.hi));
        chk("divZero", 64'(divZero), 64'(e.zero));
      end
    end else begin
      if (divZero) chk("zero_without_done", 64'(divZero), 64'd0);
      if (sb.size() != 0 && cyc > sb[0].due) begin
        chk("done_late", 64'(cyc), 64'(sb[0].due));
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    div_start = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi", 64'(hi_out), 64'd0);
    chk("rst_lo", 64'(lo_out), 64'd0);
    chk("rst_done", 64'(div_done), 64'd0);
    chk("rst_zero", 64'(divZero), 64'd0);
    reset = 1'b0;

    // Basic positive division, then divide-by-zero keeping prior results
    do_start(32'd100, 32'd7, 1'b1);
    wait_idle();
    do_start(32'd5, 32'd0, 1'b1);
    wait_idle();
    // Start right after ZERO is accepted
    do_start(-32'sd7, 32'd2, 1'b1);
    wait_idle();
    do_start(32'd7, -32'sd2, 1'b1);
    wait_idle();
    do_start(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_idle();
    do_start(32'd0, -32'sd3, 1'b1);
    wait_idle();

    // Start ignored while busy, then back-to-back start after DONE
    do_start(32'd100, 32'd7, 1'b1);
    repeat (8) @(negedge clk);
    do_start(32'd9, 32'd3, 1'b0);
    wait_idle();
    do_start(32'd12345, 32'd0, 1'b1);
    wait_idle();
    do_start(32'h7FFF_FFFF, 32'd1, 1'b1);
    wait_idle();

    // Random operands
    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (rb == 32'd0) rb = 32'd3;
      if (i == 5) ra = 32'h8000_0000;
      do_start(ra, rb, 1'b1);
      wait_idle();
    end

    // Reset aborts an operation in flight
    do_start(32'd1000, 32'd3, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_hi", 64'(hi_out), 64'd0);
    chk("abort_lo", 64'(lo_out), 64'd0);
    chk("abort_done", 64'(div_done), 64'd0);
    reset = 1'b0;
    last_hi = '0;
    last_lo = '0;
    repeat (40) @(negedge clk);
    do_start(-32'sd100, 32'd7, 1'b1);
    wait_idle();
    do_start(32'd1, 32'd0, 1'b1);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
